// File: rtl/nco_phase_gen_pkg.sv
// Shared definitions for the NCO front end, the cosine LUT wrapper and the DAC stages.
package nco_phase_gen_pkg;

  localparam int NCO_PHASE_WIDTH = 24;
  localparam int NCO_ADDR_WIDTH  = 10;
  localparam int NCO_DATA_WIDTH  = 16;
  localparam int NCO_CNT_WIDTH   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } nco_state_e;

endpackage

// File: rtl/nco_phase_gen_phase_acc.sv
// Phase accumulator with offset adder; the LUT address is the truncated top bits of acc + ofs.
module phase_acc #(
  parameter int PW = 24,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic          i_step,
  input  logic [PW-1:0] i_fcw,
  input  logic [PW-1:0] i_ofs,
  output logic [AW-1:0] o_addr
);

  localparam int SHIFT = PW - AW;

  logic [PW-1:0] r_acc;
  logic [AW-1:0] r_addr;
  logic [PW-1:0] w_base;
  logic [PW-1:0] w_sum;
  logic [AW-1:0] w_addr;

  // Sample 0 of a run always sits at the bare offset, so a load adds the offset to zero.
  assign w_base = i_load ? '0 : r_acc;
  assign w_sum  = w_base + i_ofs;
  assign w_addr = AW'(w_sum >> SHIFT);
  assign o_addr = r_addr;

  // Load restarts the phase at fcw; step advances it and registers the next address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_addr <= '0;
    end else if (i_load) begin
      r_acc  <= i_fcw;
      r_addr <= w_addr;
    end else if (i_step) begin
      r_acc  <= r_acc + i_fcw;
      r_addr <= w_addr;
    end
  end

endmodule

// File: rtl/nco_phase_gen.sv
// NCO front end: config latch, run/drain sequencing, LUT address issue and sample register.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for start; config handshake open
// ST_RUN   | issuing one LUT address per cycle
// ST_DRAIN | nothing issued; last sample's out_valid completes here
module nco_phase_gen
  import nco_phase_gen_pkg::*;
#(
  parameter int PHASE_WIDTH = NCO_PHASE_WIDTH,
  parameter int ADDR_WIDTH  = NCO_ADDR_WIDTH,
  parameter int DATA_WIDTH  = NCO_DATA_WIDTH,
  parameter int CNT_WIDTH   = NCO_CNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [PHASE_WIDTH-1:0] cfg_fcw,
  input  logic [PHASE_WIDTH-1:0] cfg_phase_ofs,
  input  logic [CNT_WIDTH-1:0]   cfg_num,
  input  logic                   start,
  input  logic                   stop,
  output logic [ADDR_WIDTH-1:0]  lut_rd_addr,
  input  logic [DATA_WIDTH-1:0]  lut_rd_data,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   busy
);

  nco_state_e             r_state;
  logic [PHASE_WIDTH-1:0] r_fcw;
  logic [PHASE_WIDTH-1:0] r_ofs;
  logic [CNT_WIDTH-1:0]   r_num;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic                   r_addr_valid;
  logic                   r_out_valid;
  logic [DATA_WIDTH-1:0]  r_out_data;

  logic                   w_idle;
  logic                   w_cfg_acc;
  logic                   w_start;
  logic                   w_end;
  logic                   w_step;
  logic [PHASE_WIDTH-1:0] w_fcw;
  logic [PHASE_WIDTH-1:0] w_ofs;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_cfg_acc = cfg_valid && w_idle;
  assign w_start   = start && w_idle;
  // A config accepted on the start edge must already govern sample 0.
  assign w_fcw     = w_cfg_acc ? cfg_fcw : r_fcw;
  assign w_ofs     = w_cfg_acc ? cfg_phase_ofs : r_ofs;
  assign w_end     = stop || ((r_num != '0) && (r_cnt == r_num));
  assign w_step    = (r_state == ST_RUN) && !w_end;

  assign cfg_ready = w_idle;
  assign busy      = !w_idle || r_out_valid;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  phase_acc #(
    .PW (PHASE_WIDTH),
    .AW (ADDR_WIDTH)
  ) u_phase_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_start),
    .i_step (w_step),
    .i_fcw  (w_fcw),
    .i_ofs  (w_ofs),
    .o_addr (lut_rd_addr)
  );

  // Run sequencing: config latch, sample counter and address-valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_fcw        <= '0;
      r_ofs        <= '0;
      r_num        <= '0;
      r_cnt        <= '0;
      r_addr_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cfg_acc) begin
            r_fcw <= cfg_fcw;
            r_ofs <= cfg_phase_ofs;
            r_num <= cfg_num;
          end
          if (start) begin
            r_state      <= ST_RUN;
            r_cnt        <= CNT_WIDTH'(1);
            r_addr_valid <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_end) begin
            r_state      <= ST_DRAIN;
            r_addr_valid <= 1'b0;
          end else begin
            r_cnt        <= r_cnt + CNT_WIDTH'(1);
            r_addr_valid <= 1'b1;
          end
        end
        ST_DRAIN: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state      <= ST_IDLE;
          r_addr_valid <= 1'b0;
        end
      endcase
    end
  end

  // Capture the LUT word one cycle after its address was issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_out_valid <= r_addr_valid;
      if (r_addr_valid) begin
        r_out_data <= lut_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_nco_phase_gen.sv
// Bench for nco_phase_gen with an identity LUT (LUT[i] = i) and a sample scoreboard.
module tb_nco_phase_gen;

  logic        clk;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [23:0] cfg_fcw;
  logic [23:0] cfg_phase_ofs;
  logic [15:0] cfg_num;
  logic        start;
  logic        stop;
  logic [9:0]  lut_rd_addr;
  logic [15:0] lut_rd_data;
  logic        out_valid;
  logic [15:0] out_data;
  logic        busy;

  logic [15:0] exp_q[$];
  int n_chk;
  int n_pass;

  nco_phase_gen dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_fcw       (cfg_fcw),
    .cfg_phase_ofs (cfg_phase_ofs),
    .cfg_num       (cfg_num),
    .start         (start),
    .stop          (stop),
    .lut_rd_addr   (lut_rd_addr),
    .lut_rd_data   (lut_rd_data),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .busy          (busy)
  );

  assign lut_rd_data = {6'b0, lut_rd_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
  endtask

  function automatic logic [15:0] exp_sample(input int k, input logic [23:0] fcw, input logic [23:0] ofs);
    longint unsigned t;
    t = longint'(k) * longint'(fcw) + longint'(ofs);
    return {6'b0, t[23:14]};
  endfunction

  // Every delivered sample must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) chk("extra_sample", 32'd1, 32'd0);
      else chk("sample", {16'b0, out_data}, {16'b0, exp_q.pop_front()});
    end
  end

  task automatic do_run(input logic [23:0] fcw, input logic [23:0] ofs, input logic [15:0] num,
                        input bit cfg_with_start, input int stop_at, input bit probe, input string name);
    int n, first_i, last_i, idle_i, pulses;
    n = (stop_at > 0) ? stop_at : int'(num);
    for (int k = 0; k < n; k++) exp_q.push_back(exp_sample(k, fcw, ofs));
    if (!cfg_with_start) begin
      @(negedge clk);
      cfg_valid = 1'b1; cfg_fcw = fcw; cfg_phase_ofs = ofs; cfg_num = num;
      @(negedge clk);
      cfg_valid = 1'b0;
    end
    @(negedge clk);
    if (cfg_with_start) begin
      cfg_valid = 1'b1; cfg_fcw = fcw; cfg_phase_ofs = ofs; cfg_num = num;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cfg_valid = 1'b0;
    first_i = -1; last_i = -1; idle_i = -1; pulses = 0;
    for (int i = 0; i < 3000; i++) begin
      if (out_valid) begin
        pulses++;
        if (first_i < 0) first_i = i;
        last_i = i;
      end
      if (i > 0 && cfg_ready && idle_i < 0) idle_i = i;
      if (probe && i == 2) begin
        chk({name, "_cfg_ready_run"}, {31'b0, cfg_ready}, 32'd0);
        start = 1'b1; cfg_valid = 1'b1; cfg_fcw = 24'h123457; cfg_num = 16'd1;
      end
      if (probe && i == 3) begin start = 1'b0; cfg_valid = 1'b0; end
      if (probe && num != 0 && i == int'(num)) begin stop = 1'b1; start = 1'b1; end
      if (probe && num != 0 && i == int'(num) + 1) begin stop = 1'b0; start = 1'b0; end
      if (stop_at > 0 && i == stop_at - 1) stop = 1'b1;
      if (stop_at > 0 && i == stop_at) stop = 1'b0;
      if (idle_i >= 0 && i >= idle_i + 3) break;
      @(negedge clk);
    end
    chk({name, "_first"}, first_i, 1);
    chk({name, "_last"}, last_i, n);
    chk({name, "_pulses"}, pulses, n);
    chk({name, "_idle"}, idle_i, n + 1);
    chk({name, "_q_empty"}, exp_q.size(), 0);
    chk({name, "_busy_end"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk = 0; n_pass = 0;
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_fcw = '0; cfg_phase_ofs = '0; cfg_num = '0;
    start = 1'b0; stop = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cfg_ready", {31'b0, cfg_ready}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", {16'b0, out_data}, 32'd0);
    chk("rst_addr", {22'b0, lut_rd_addr}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_run(24'h004000, 24'h100000, 16'd4, 1'b0, 0, 1'b0, "t1_basic");
    do_run(24'hC00000, 24'h000000, 16'd3, 1'b0, 0, 1'b0, "t2_wrap");
    do_run(24'h004000, 24'h000000, 16'd0, 1'b0, 10, 1'b0, "t3_stop10");
    do_run(24'h004000, 24'h000000, 16'd0, 1'b0, 1030, 1'b0, "t3_cont_wrap");
    do_run(24'h008000, 24'h000000, 16'd2, 1'b1, 0, 1'b0, "t4_cfg_start");
    do_run(24'h010000, 24'h000400, 16'd5, 1'b0, 0, 1'b1, "t5_ignore");

    // Asynchronous reset in the middle of a continuous run.
    for (int k = 0; k < 40; k++) exp_q.push_back(exp_sample(k, 24'h004000, 24'h0));
    @(negedge clk);
    cfg_valid = 1'b1; cfg_fcw = 24'h004000; cfg_phase_ofs = '0; cfg_num = '0; start = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0; start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", {31'b0, busy}, 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_out_data", {16'b0, out_data}, 32'd0);
    chk("arst_addr", {22'b0, lut_rd_addr}, 32'd0);
    chk("arst_cfg_ready", {31'b0, cfg_ready}, 32'd1);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("post_rst_no_valid", {31'b0, out_valid}, 32'd0);
    end

    do_run(24'h020000, 24'h008000, 16'd3, 1'b1, 0, 1'b0, "t6_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
